// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data memory.
// Pure declarations: no latency, no flow control.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data copied into every lane it could land in.
    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane extraction and sign/zero extension; purely combinational.
// Zero latency, no flow control; reserved size yields 0.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = word >> {addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_lo[1] ? word[31:16] : word[15:0];
        data    = '0;
        case (size)
            SZ_BYTE: data = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{is_signed & half_v[15]}}, half_v};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory with hardware clear after reset; one request per cycle.
// Response one cycle after acceptance; no response backpressure, req_ready low while clearing.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter logic [31:0] LIMIT  = 32'h0000_2fff,
    parameter bit          TRACE  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned         DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0]   CLR_LAST = '1;

    logic [31:0] mem_q [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_load_q, rsp_load_d;
    logic [1:0]          rsp_lo_q, rsp_lo_d;
    logic [1:0]          rsp_size_q, rsp_size_d;
    logic                rsp_signed_q, rsp_signed_d;
    logic [31:0]         rd_word_q;

    logic [ADDR_W-1:0]   word_idx;
    logic                misalign, out_of_range, req_err, accept, rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;
    logic [31:0]         wr_dat;
    logic [3:0]          wr_be;
    logic [31:0]         ext_data;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        req_ready = (state_q == RUN);
        busy      = (state_q == CLEAR);
    end

    // Request decode; BASE is word aligned so lanes come straight from req_addr.
    always_comb begin
        word_idx     = ADDR_W'((req_addr - BASE) >> 2);
        misalign     = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr < BASE) || (req_addr > LIMIT);
        req_err      = (req_size == SZ_RSVD) || misalign || out_of_range;
        accept       = req_valid && req_ready && !reset;
        rd_en        = accept && !req_we && !req_err;
    end

    // Single write port shared by the clear sequence and stores.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = word_idx;
        wr_dat = wdata_rep(req_size, req_wdata);
        wr_be  = lane_be(req_size, req_addr[1:0]);
        if (state_q == CLEAR) begin
            wr_en  = !reset;
            wr_idx = clr_cnt_q;
            wr_dat = '0;
            wr_be  = 4'b1111;
        end else if (accept && req_we && !req_err) begin
            wr_en  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_word_q <= mem_q[word_idx];
        end
    end

    always_comb begin
        rsp_valid_d  = accept;
        rsp_err_d    = accept && req_err;
        rsp_load_d   = rd_en;
        rsp_lo_d     = accept ? req_addr[1:0] : rsp_lo_q;
        rsp_size_d   = accept ? req_size      : rsp_size_q;
        rsp_signed_d = accept ? req_signed    : rsp_signed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_load_q   <= 1'b0;
            rsp_lo_q     <= 2'b00;
            rsp_size_q   <= SZ_BYTE;
            rsp_signed_q <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_load_q   <= rsp_load_d;
            rsp_lo_q     <= rsp_lo_d;
            rsp_size_q   <= rsp_size_d;
            rsp_signed_q <= rsp_signed_d;
        end
    end

    dmem_load_ext u_load_ext (
        .word      (rd_word_q),
        .addr_lo   (rsp_lo_q),
        .size      (rsp_size_q),
        .is_signed (rsp_signed_q),
        .data      (ext_data)
    );

    // Stores and errors always return zero data.
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = rsp_load_q ? ext_data : '0;
    end

`ifndef SYNTHESIS
    if (TRACE) begin : g_trace
        logic [31:0] merged;
        always_comb begin
            merged = mem_q[word_idx];
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    merged[8*b +: 8] = wr_dat[8*b +: 8];
                end
            end
        end
        always @(posedge clk) begin
            if (state_q == RUN && wr_en) begin
                $display("[dmem] t=%0t pc=%08h addr=%08h data=%08h",
                         $time, req_pc, {req_addr[31:2], 2'b00}, merged);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync: scoreboarded responses on the default instance,
// plus a small instance exercising a non-zero BASE and a 16-word clear.
module tb_dmem_sync;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready, req_we, req_signed;
    logic [31:0] req_addr, req_wdata, req_pc, rsp_rdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err, busy;

    logic        s_reset, s_req_valid, s_req_ready, s_req_we, s_req_signed;
    logic [31:0] s_req_addr, s_req_wdata, s_req_pc, s_rsp_rdata;
    logic [1:0]  s_req_size;
    logic        s_rsp_valid, s_rsp_err, s_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    dmem_sync u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_sync #(.ADDR_W(4), .BASE(32'h0000_0100), .LIMIT(32'h0000_013f), .TRACE(1'b0)) u_small (
        .clk(clk), .reset(s_reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_we(s_req_we), .req_addr(s_req_addr), .req_size(s_req_size),
        .req_signed(s_req_signed), .req_wdata(s_req_wdata), .req_pc(s_req_pc),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_rsp observed=rsp_valid=1 expected=no response");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata, input string tag);
        int guard;
        req_we = we; req_addr = addr; req_size = size; req_signed = sgn;
        req_wdata = wdata; req_pc = 32'h0040_0000 + addr; req_valid = 1'b1;
        sb_q.push_back('{exp_err, exp_rdata, tag});
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_ready_timeout observed=req_ready low expected=high", tag);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic count_busy(output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        forever begin
            @(negedge clk);
            if (busy !== 1'b1 || cnt > 10000) break;
            cnt++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
        end
    endtask

    task automatic s_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata, input string tag);
        int guard;
        s_req_we = we; s_req_addr = addr; s_req_size = size; s_req_signed = sgn;
        s_req_wdata = wdata; s_req_pc = 32'h0040_1000; s_req_valid = 1'b1;
        guard = 0;
        while (s_req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 s_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, s_rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, s_rsp_err}, {31'd0, exp_err});
        chk({tag, "_rdata"}, s_rsp_rdata, exp_rdata);
    endtask

    initial begin
        int cnt, bad;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd2;
        req_signed = 1'b0; req_wdata = '0; req_pc = '0;
        s_reset = 1'b1; s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = '0;
        s_req_size = 2'd2; s_req_signed = 1'b0; s_req_wdata = '0; s_req_pc = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);

        // A load held through the whole clear must only be taken afterwards.
        @(posedge clk);
        #1;
        req_we = 1'b0; req_addr = 32'h0000_2ffc; req_size = 2'd2; req_signed = 1'b0;
        req_valid = 1'b1;
        sb_q.push_back('{1'b0, 32'h0, "lw_2ffc_after_clear"});
        reset = 1'b0;
        count_busy(cnt, bad);
        chk("busy_cycles", cnt, 32'd4096);
        chk("busy_ready_or_rsp", bad, 32'd0);
        chk("ready_after_clear", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        issue(1'b1, 32'h10, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 32'h0, "sw_10");
        issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 1'b0, 32'h0000_0012, "lb_13");
        issue(1'b0, 32'h10, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0000_0078, "lbu_10");
        issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0000_1234, "lh_12");
        issue(1'b0, 32'h10, 2'd2, 1'b1, 32'h0, 1'b0, 32'h1234_5678, "lw_10");

        issue(1'b1, 32'h21, 2'd0, 1'b0, 32'hffff_ff80, 1'b0, 32'h0, "sb_21");
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0000_8000, "lw_20");
        issue(1'b0, 32'h21, 2'd0, 1'b1, 32'h0, 1'b0, 32'hffff_ff80, "lb_21");
        issue(1'b0, 32'h21, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0000_0080, "lbu_21");
        issue(1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_beef, 1'b0, 32'h0, "sh_22");
        issue(1'b0, 32'h22, 2'd1, 1'b1, 32'h0, 1'b0, 32'hffff_beef, "lh_22");
        issue(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0000_beef, "lhu_22");
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 32'hbeef_8000, "lw_20b");

        issue(1'b1, 32'h4, 2'd2, 1'b0, 32'hcafe_f00d, 1'b0, 32'h0, "sw_4");
        issue(1'b1, 32'h6, 2'd2, 1'b0, 32'h1111_1111, 1'b1, 32'h0, "sw_6_err");
        issue(1'b1, 32'h5, 2'd1, 1'b0, 32'h2222_2222, 1'b1, 32'h0, "sh_5_err");
        issue(1'b1, 32'h0, 2'd3, 1'b0, 32'h3333_3333, 1'b1, 32'h0, "sz3_0_err");
        issue(1'b1, 32'h3000, 2'd2, 1'b0, 32'h4444_4444, 1'b1, 32'h0, "sw_3000_err");
        issue(1'b0, 32'h6, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, "lw_6_err");
        issue(1'b0, 32'h5, 2'd1, 1'b1, 32'h0, 1'b1, 32'h0, "lh_5_err");
        issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1'b0, 32'hcafe_f00d, "lw_4_intact");
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, "lw_0_intact");

        // Reset lands on the store's response cycle while a load is presented.
        issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hdead_beef, 1'b0, 32'h0, "sw_40");
        req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2; req_valid = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_drops_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy_again", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        count_busy(cnt, bad);
        chk("busy_cycles_rerun", cnt, 32'd4096);
        chk("busy_rerun_ready_or_rsp", bad, 32'd0);
        issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, "lw_40_cleared");
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, "lw_10_cleared");
        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        // Small instance: BASE 0x100, 16 words.
        @(posedge clk);
        #1 s_reset = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (s_busy !== 1'b1 || cnt > 1000) break;
            cnt++;
        end
        chk("small_busy_cycles", cnt, 32'd16);
        s_req(1'b1, 32'h13c, 2'd2, 1'b0, 32'ha5a5_a5a5, 1'b0, 32'h0, "small_sw_13c");
        s_req(1'b1, 32'h140, 2'd2, 1'b0, 32'h5a5a_5a5a, 1'b1, 32'h0, "small_sw_140_err");
        s_req(1'b0, 32'h13c, 2'd2, 1'b0, 32'h0, 1'b0, 32'ha5a5_a5a5, "small_lw_13c");
        s_req(1'b0, 32'h13f, 2'd0, 1'b1, 32'h0, 1'b0, 32'hffff_ffa5, "small_lb_13f");
        s_req(1'b0, 32'h0fc, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, "small_lw_fc_err");
        s_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, "small_lw_100");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
